apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB completer that answers the one-hot `psel` strobe driven by our AHB-to-APB bridge controller. It has a small bank of 32-bit registers, a programmable number of wait states signalled on `pready`, and optional error reporting on `pslverr`. One instance sits behind each `psel` bit on the APB side of the bridge. It is the peripheral-side endpoint we use for bridge bring-up and system tests.

## Interface
- `NUM_REGS`, 8: number of 32-bit registers; power of two, 2..256.
- `WAIT_STATES`, 1: `pready`-low cycles inserted in each access phase; 0..15.
- `SEL_INDEX`, 0: which bit of `psel[2:0]` selects this instance.
- `hclk` in 1: single clock; all state changes on its rising edge.
- `hresetn` in 1: asynchronous, active-low reset.
- `psel` in 3: one-hot slave select from the bridge. Only bit `SEL_INDEX` is used.
- `penable` in 1: access-phase strobe.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in 32: byte address. Bits [1:0] are the alignment bits; bits [9:2] are the word index.
- `pwdata` in 32: write data.
- `pready` out 1: transfer completes in a cycle where `pready`, `sel` and `penable` are all high.
- `prdata` out 32: read data, valid while `pready`=1 on a read.
- `pslverr` out 1: error response, valid while `pready`=1.

## Operation
- `sel` = `psel[SEL_INDEX]`.
- Setup phase is `sel` & !`penable`.
- Access phase is `sel` & `penable`.

Decode:
- idx = `paddr[9:2]`.
- The address is in range when idx < `NUM_REGS` and `paddr[1:0]` = 0.
- Registers 0..`NUM_REGS`-2 are read/write.
- Register `NUM_REGS`-1 is the read-only WCOUNT: a 32-bit count of committed writes, wrapping 0xFFFFFFFF -> 0.
- A write to WCOUNT is an illegal access.

State machine (`ST_IDLE`, `ST_WAIT`, `ST_READY`):
- `ST_IDLE`, on setup phase:
  - latch address, direction, wdata and the legal flag;
  - load the wait counter with `WAIT_STATES`;
  - go to `ST_READY` if `WAIT_STATES`=0, else `ST_WAIT`.
- `ST_WAIT`:
  - counter decrements every cycle;
  - go to `ST_READY` on the edge where counter==1.
- `ST_READY`:
  - `pready`=1;
  - on the edge where the access phase is present: commit, then go to `ST_IDLE`.

Commit:
- A legal write updates reg[idx] and increments WCOUNT.
- A legal read has no side effect.
- An illegal access changes no register.

Protocol violation:
- If `sel` drops in `ST_WAIT` or `ST_READY`, go to `ST_IDLE` with no commit and no WCOUNT change.
- `penable` seen high in `ST_IDLE` is ignored.

Outputs (all registered):
- `prdata` = latched reg[idx] in `ST_READY` on a legal read, else 0.
- `pslverr` = `ST_READY` & illegal.

## Timing
- Reset (async assert, sync release):
  - all outputs 0;
  - state `ST_IDLE`;
  - all registers and WCOUNT 0.
- Reset during a transfer drops it immediately, with no commit.
- Access phase length is `WAIT_STATES`+1 cycles. Total transfer length is `WAIT_STATES`+2 cycles including setup.
- Read data is sampled into `prdata` at the edge entering `ST_READY`. It is stable through the `pready`=1 cycle.
- A write is visible to a read whose setup starts on the cycle after the commit edge. Back-to-back transfers need no idle cycle.
- `pready` deasserts on the edge after the completing cycle.

## Configuration
- `APB_SLAVE_PSLVERR_EN` defined: illegal accesses assert `pslverr` during the `pready` cycle. Illegal means out of range, misaligned, or a write to WCOUNT.
- `APB_SLAVE_PSLVERR_EN` undefined:
  - `pslverr` is tied 0;
  - illegal reads return 0;
  - illegal writes are silently dropped;
  - WCOUNT is still not incremented.

## Structure
- Shared package `apb_pkg` holds:
  - the state encoding (`ST_IDLE`=2'b00, `ST_WAIT`=2'b01, `ST_READY`=2'b10);
  - the APB data and address width constants;
  - the `psel` width (3).
- One sub-module, `apb_regbank`. It contains the register array, the WCOUNT register and the legal-decode logic. It exposes a read port, a write port with enable, and the legal flag.
- The top level contains the FSM, the wait counter and the output registers.

## Test plan
- Reset mid-`ST_WAIT` with `WAIT_STATES`=3 -> outputs 0 immediately, WCOUNT stays 0, and the next transfer works.
- Write 0xDEADBEEF to 0x04, then read 0x04 (`WAIT_STATES`=1) -> `pready` high in the 3rd cycle of each transfer, `prdata`=0xDEADBEEF, WCOUNT=1.
- Read 0x20 with `NUM_REGS`=8, with `APB_SLAVE_PSLVERR_EN` defined -> `pslverr`=1, `prdata`=0. Same read with the macro undefined -> `pslverr`=0, `prdata`=0.
- Write to 0x1C (WCOUNT) and to misaligned address 0x06 -> no register changes, WCOUNT unchanged, `pslverr`=1 when the macro is defined.
- `WAIT_STATES`=0 with back-to-back writes to 0x00 and 0x08 and no idle cycle -> each transfer completes in 2 cycles, WCOUNT=2.
- `psel[SEL_INDEX]` dropped in `ST_READY` before `penable` rises, and `psel` driven on a different bit -> no commit, and `pready` stays 0 for the other-bit access.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the completer state encoding.
package apb_pkg;

  localparam int APB_DW   = 32;
  localparam int APB_AW   = 32;
  localparam int APB_SELW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_READY = 2'b10
  } apb_state_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the bridge (master) and one completer (slave).
interface apb_slave_regfile_if;
  import apb_pkg::*;

  // A transfer completes in the cycle where psel[i], penable and pready are
  // all high; the master holds address, direction and data stable until then.
  logic [APB_SELW-1:0] psel;
  logic                penable;
  logic                pwrite;
  logic [APB_AW-1:0]   paddr;
  logic [APB_DW-1:0]   pwdata;
  logic                pready;
  logic [APB_DW-1:0]   prdata;
  logic                pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_regbank.sv
// Register array whose last entry is the read-only WCOUNT write counter,
// plus the address legality decode used by the APB completer.
module apb_regbank
  import apb_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  localparam int IW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        dec_idx,
  input  logic [1:0]        dec_align,
  input  logic              dec_write,
  output logic              dec_legal,
  input  logic [IW-1:0]     rd_idx,
  output logic [APB_DW-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [APB_DW-1:0] wr_data
);

  logic [APB_DW-1:0] regs_q [NUM_REGS];
  logic [APB_DW-1:0] regs_d [NUM_REGS];

  always_comb begin
    dec_legal = ({24'd0, dec_idx} < 32'(NUM_REGS)) && (dec_align == 2'b00) &&
                !(dec_write && ({24'd0, dec_idx} == 32'(NUM_REGS - 1)));
  end

  assign rd_data = regs_q[rd_idx];

  // wr_en is only raised for legal writes, which never target WCOUNT.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_idx]       = wr_data;
      regs_d[NUM_REGS - 1] = regs_q[NUM_REGS - 1] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a small register bank and programmable wait states.
// Define APB_SLAVE_PSLVERR_EN to report illegal accesses on pslverr.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 1,
  parameter int SEL_INDEX   = 0
) (
  input  logic                hclk,
  input  logic                hresetn,
  apb_slave_regfile_if.slave  bus,
  output apb_state_t          dbg_state
);

  localparam int IW = $clog2(NUM_REGS);
`ifdef APB_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  apb_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              write_q, write_d;
  logic              legal_q, legal_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic              pready_q, pready_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;

  logic              sel, bus_legal, commit_we;
  logic              enter_rdy, enter_legal, enter_write;
  logic [IW-1:0]     rd_idx;
  logic [APB_DW-1:0] rd_data;
  logic              unused_bus;

  assign sel        = bus.psel[SEL_INDEX];
  assign unused_bus = ^{bus.paddr[APB_AW-1:10], bus.psel};

  // Zero-wait transfers sample read data straight off the bus address.
  assign rd_idx = (state_q == ST_IDLE) ? bus.paddr[IW+1:2] : idx_q;

  apb_regbank #(.NUM_REGS(NUM_REGS)) u_bank (
    .clk      (hclk),
    .rst_n    (hresetn),
    .dec_idx  (bus.paddr[9:2]),
    .dec_align(bus.paddr[1:0]),
    .dec_write(bus.pwrite),
    .dec_legal(bus_legal),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .wr_en    (commit_we),
    .wr_idx   (idx_q),
    .wr_data  (wdata_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    write_d     = write_q;
    legal_d     = legal_q;
    wdata_d     = wdata_q;
    pready_d    = 1'b0;
    prdata_d    = '0;
    pslverr_d   = 1'b0;
    commit_we   = 1'b0;
    enter_rdy   = 1'b0;
    enter_legal = legal_q;
    enter_write = write_q;
    case (state_q)
      ST_IDLE: begin
        if (sel && !bus.penable) begin
          idx_d   = bus.paddr[IW+1:2];
          write_d = bus.pwrite;
          legal_d = bus_legal;
          wdata_d = bus.pwdata;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d     = ST_READY;
            enter_rdy   = 1'b1;
            enter_legal = bus_legal;
            enter_write = bus.pwrite;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!sel) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = ST_READY;
            enter_rdy = 1'b1;
          end
        end
      end
      ST_READY: begin
        if (!sel) begin
          state_d = ST_IDLE;
        end else if (bus.penable) begin
          commit_we = write_q && legal_q;
          state_d   = ST_IDLE;
        end else begin
          pready_d  = 1'b1;
          prdata_d  = prdata_q;
          pslverr_d = pslverr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_rdy) begin
      pready_d  = 1'b1;
      prdata_d  = (enter_legal && !enter_write) ? rd_data : '0;
      pslverr_d = ERR_EN && !enter_legal;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      legal_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      legal_q   <= legal_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign bus.pready  = pready_q;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pslverr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Three completers on one APB bus (wait states 1, 0, 3 on psel bits 0, 1, 2)
// checked every cycle against a transfer-level model of the register files.
module tb_apb_slave_regfile;
  import apb_pkg::*;

`ifdef APB_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // clock / reset
  logic hclk    = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  logic [2:0]  psel    = '0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = '0;
  logic [31:0] pwdata  = '0;

  apb_slave_regfile_if bus0 ();
  apb_slave_regfile_if bus1 ();
  apb_slave_regfile_if bus2 ();
  apb_state_t dbg0, dbg1, dbg2;

  assign bus0.psel = psel; assign bus0.penable = penable; assign bus0.pwrite = pwrite;
  assign bus0.paddr = paddr; assign bus0.pwdata = pwdata;
  assign bus1.psel = psel; assign bus1.penable = penable; assign bus1.pwrite = pwrite;
  assign bus1.paddr = paddr; assign bus1.pwdata = pwdata;
  assign bus2.psel = psel; assign bus2.penable = penable; assign bus2.pwrite = pwrite;
  assign bus2.paddr = paddr; assign bus2.pwdata = pwdata;

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(1), .SEL_INDEX(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus0), .dbg_state(dbg0));
  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(0), .SEL_INDEX(1)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus1), .dbg_state(dbg1));
  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(3), .SEL_INDEX(2)) u_dut2 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus2), .dbg_state(dbg2));

  logic        pready_w  [3];
  logic [31:0] prdata_w  [3];
  logic        pslverr_w [3];
  assign pready_w[0] = bus0.pready; assign prdata_w[0] = bus0.prdata; assign pslverr_w[0] = bus0.pslverr;
  assign pready_w[1] = bus1.pready; assign prdata_w[1] = bus1.prdata; assign pslverr_w[1] = bus1.pslverr;
  assign pready_w[2] = bus2.pready; assign prdata_w[2] = bus2.prdata; assign pslverr_w[2] = bus2.pslverr;

  // model and expectations
  logic [31:0] m_regs [3][7];
  logic [31:0] m_wc   [3];
  logic        exp_pready  [3];
  logic [31:0] exp_prdata  [3];
  logic        exp_pslverr [3];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          obs_ready_n;
  logic [31:0] obs_rdata;
  logic        obs_err;

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int k, input int idx);
    if (idx == 7) return m_wc[k];
    if (idx < 7)  return m_regs[k][idx];
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_wc[k] = '0;
      for (int i = 0; i < 7; i++) m_regs[k][i] = '0;
    end
  endtask

  task automatic set_exp_idle();
    for (int k = 0; k < 3; k++) begin
      exp_pready[k]  = 1'b0;
      exp_prdata[k]  = '0;
      exp_pslverr[k] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every DUT output checked on every falling edge
  always @(negedge hclk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pready[%0d]", k),  32'(pready_w[k]),  32'(exp_pready[k]));
      check($sformatf("prdata[%0d]", k),  prdata_w[k],       exp_prdata[k]);
      check($sformatf("pslverr[%0d]", k), 32'(pslverr_w[k]), 32'(exp_pslverr[k]));
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge hclk); #1;
      psel = '0; penable = 1'b0;
      set_exp_idle();
    end
  endtask

  task automatic reset_cycles(input int n);
    hresetn = 1'b0;
    model_reset();
    repeat (n) begin
      @(posedge hclk); #1;
      psel = '0; penable = 1'b0;
      set_exp_idle();
    end
    hresetn = 1'b1;
  endtask

  // One transfer to completer k. drop_at / rst_at (1-based cycle, 0 = never)
  // abandon it by deselecting or by asserting reset mid-cycle.
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input int drop_at, input int rst_at);
    int idx, nlast;
    bit legal;
    idx   = int'(addr[9:2]);
    legal = (idx < 8) && (addr[1:0] == 2'b00) && !(wr && idx == 7);
    nlast = ws_of(k) + 2;
    obs_ready_n = 0; obs_rdata = '0; obs_err = 1'b0;
    for (int n = 1; n <= nlast; n++) begin
      @(posedge hclk); #1;
      if (n == drop_at) begin
        psel = '0; penable = 1'b0;
      end else begin
        psel = 3'(1 << k); penable = (n > 1); pwrite = wr; paddr = addr; pwdata = wd;
      end
      set_exp_idle();
      if (n == nlast) begin
        exp_pready[k]  = 1'b1;
        exp_prdata[k]  = (legal && !wr) ? m_read(k, idx) : 32'd0;
        exp_pslverr[k] = ERR_EN && !legal;
      end
      if (n == rst_at) begin
        set_exp_idle();
        model_reset();
        hresetn = 1'b0;
      end
      @(negedge hclk);
      if (pready_w[k] && obs_ready_n == 0) begin
        obs_ready_n = n; obs_rdata = prdata_w[k]; obs_err = pslverr_w[k];
      end
      if (n == drop_at || n == rst_at) return;
    end
    if (legal && wr) begin
      m_regs[k][idx] = wd;
      m_wc[k]        = m_wc[k] + 32'd1;
    end
  endtask

  initial begin
    set_exp_idle();
    model_reset();
    reset_cycles(2);
    check("dbg0_reset", 32'(dbg0), 32'(ST_IDLE));
    check("dbg1_reset", 32'(dbg1), 32'(ST_IDLE));
    check("dbg2_reset", 32'(dbg2), 32'(ST_IDLE));

    // reset while completer 2 (3 wait states) is waiting
    xfer(2, 1'b1, 32'h00, 32'h1234_5678, 0, 2);
    reset_cycles(2);
    xfer(2, 1'b0, 32'h1C, 32'h0, 0, 0);
    check("wait3_ready_cycle", 32'(obs_ready_n), 32'd5);
    check("wcount_after_rst", obs_rdata, 32'd0);
    xfer(2, 1'b1, 32'h00, 32'hA5A5_A5A5, 0, 0);
    xfer(2, 1'b0, 32'h00, 32'h0, 0, 0);
    check("dut2_readback", obs_rdata, 32'hA5A5_A5A5);

    // basic write/read with one wait state
    xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF, 0, 0);
    check("wr_ready_cycle", 32'(obs_ready_n), 32'd3);
    xfer(0, 1'b0, 32'h04, 32'h0, 0, 0);
    check("rd_ready_cycle", 32'(obs_ready_n), 32'd3);
    check("rd_deadbeef", obs_rdata, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h1C, 32'h0, 0, 0);
    check("wcount_1", obs_rdata, 32'd1);

    // illegal accesses
    xfer(0, 1'b0, 32'h20, 32'h0, 0, 0);
    check("oor_err", 32'(obs_err), 32'(ERR_EN));
    check("oor_rdata", obs_rdata, 32'd0);
    xfer(0, 1'b1, 32'h1C, 32'h55, 0, 0);
    check("wcount_wr_err", 32'(obs_err), 32'(ERR_EN));
    xfer(0, 1'b1, 32'h06, 32'h66, 0, 0);
    check("misalign_err", 32'(obs_err), 32'(ERR_EN));
    xfer(0, 1'b0, 32'h04, 32'h0, 0, 0);
    check("reg1_unchanged", obs_rdata, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h1C, 32'h0, 0, 0);
    check("wcount_still_1", obs_rdata, 32'd1);

    // zero wait states, back to back
    xfer(1, 1'b1, 32'h00, 32'h1111_1111, 0, 0);
    check("b2b_first_cycle", 32'(obs_ready_n), 32'd2);
    xfer(1, 1'b1, 32'h08, 32'h2222_2222, 0, 0);
    check("b2b_second_cycle", 32'(obs_ready_n), 32'd2);
    xfer(1, 1'b0, 32'h1C, 32'h0, 0, 0);
    check("wcount_2", obs_rdata, 32'd2);
    xfer(1, 1'b0, 32'h08, 32'h0, 0, 0);
    check("reg2_readback", obs_rdata, 32'h2222_2222);

    // deselect in ST_READY before penable rises
    idle(1);
    xfer(1, 1'b1, 32'h00, 32'h0000_0099, 2, 0);
    idle(1);
    xfer(1, 1'b0, 32'h00, 32'h0, 0, 0);
    check("drop_no_commit", obs_rdata, 32'h1111_1111);

    // penable already high while idle is not a setup phase
    @(posedge hclk); #1;
    psel = 3'b010; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFFFF_FFFF;
    set_exp_idle();
    @(posedge hclk); #1;
    set_exp_idle();
    idle(1);
    xfer(1, 1'b0, 32'h1C, 32'h0, 0, 0);
    check("wcount_still_2", obs_rdata, 32'd2);

    // reset while completer 0 presents read data
    xfer(0, 1'b0, 32'h04, 32'h0, 0, 3);
    check("rst_pready_now", 32'(pready_w[0]), 32'd0);
    check("rst_prdata_now", prdata_w[0], 32'd0);
    reset_cycles(2);
    xfer(0, 1'b0, 32'h04, 32'h0, 0, 0);
    check("reg1_cleared", obs_rdata, 32'd0);
    xfer(0, 1'b0, 32'h1C, 32'h0, 0, 0);
    check("wcount_cleared", obs_rdata, 32'd0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
